ans_stage: RTL and testbench
============================

# ans_stage

Parametrised noise-shaping stage for the ANS-PWM cascade, generalising the fixed 16-bit second stage. Each accepted sample is quantised to QB coarse bits with error feedback. The stage then applies an ORDER-fold first-difference (1 − z⁻¹)^ORDER, delays the result DELAY samples for alignment at the final signed adder, and forwards the left-aligned residue to the next stage. The pipeline advances only on `in_valid`, so stages can run at the PWM frame rate from a fast clock.

## Interface
- `W`, 16: input/residue width, bits.
- `QB`, 4: coarse quantiser bits, 1..W-1.
- `ORDER`, 1: differentiator order, 0..3.
- `DELAY`, 2: alignment delay in samples, 0..8.
- `CMAX`, 2^(QB+ORDER+1)-1: saturation limit on `C` (used only with `ANS_STAGE_SAT_EN`).
- Derived: OW = QB+ORDER+1 (magnitude width).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  sample enable; `A` is consumed on cycles where it is 1.
- `A`  in  W  unsigned target (fraction of full scale).
- `out_valid`  out  1  one-cycle pulse; `C`, `Csgn` and `nxttgt` updated.
- `C`  out  OW  magnitude of the delayed differentiated quant.
- `Csgn`  out  1  sign of `C` (1 = negative).
- `nxttgt`  out  W  residue for the next stage, left-aligned.
- `sat`  out  1  sticky saturation flag.

## Operation
- Registers: residue `r` (W-QB bits), ORDER history words, DELAY-deep sign-magnitude delay line, output registers. All advance only when `in_valid`=1 in a cycle where `rst_n`=1. Otherwise everything holds.
- Quantiser: s = A + r, computed as W+1 bits unsigned. q = s >> (W-QB), with range 0..2^QB. r ← s mod 2^(W-QB).
- `nxttgt` ← r_new << QB; the low QB bits are 0.
- Differentiator: cascade of ORDER first differences, y_k = y_{k-1}[n] − y_{k-1}[n-1], with y_0 = q. Each history register is reset to 0. Signed width is OW+1, so there is no overflow.
- ORDER=0: d = q.
- Sign-magnitude: `Csgn` = (d<0), C = |d|. A value of 0 always has `Csgn`=0.
- Delay line: d for sample n appears on `C`/`Csgn` at sample n+DELAY. DELAY=0 means no delay stage. Entries reset to magnitude 0, sign 0.
- Reset: every register and output is cleared to 0, including `out_valid` and `sat`. `in_valid` is ignored while `rst_n`=0.
- Reset asserted mid-stream discards all history. The first sample after release behaves exactly like the first sample after power-up.

## Timing
- `in_valid`=1 in cycle t: at the edge ending t, `C`/`Csgn` take the delayed result and `nxttgt` takes the residue of this sample. `out_valid`=1 during cycle t+1 only.
- Back-to-back `in_valid` gives one result per cycle with no bubbles.
- Sample latency is DELAY samples on `C` and 0 samples on `nxttgt`, both registered one clock after acceptance.
- While `in_valid`=0, outputs hold their last values and `out_valid`=0.

## Configuration
- `ANS_STAGE_SAT_EN` defined: after sign-magnitude conversion and before the delay line, C = min(|d|, CMAX). `Csgn` is unchanged. `sat` is set on the first clamped sample and stays set until reset.
- `ANS_STAGE_SAT_EN` undefined: no clamp, and `sat` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 clks with `in_valid`=1 and A=0xFFFF. Then `C`=0, `Csgn`=0, `nxttgt`=0, `out_valid`=0, `sat`=0 throughout.
- Default parameters, constant A=0x8000, continuous valid: samples 0,1 give C=0; sample 2 gives C=8, `Csgn`=0; then C=0 forever. `nxttgt`=0 throughout.
- A=0x0800 continuous: q alternates 0,1,0,1. After the 2-sample delay, C = 0,1,1,1… with `Csgn` = 0,0,1,0,1… `nxttgt` alternates 0x8000, 0x0000.
- Repeat the 0x0800 run with `in_valid` deasserted for 5 random gaps. The `C`/`Csgn`/`nxttgt` sequence sampled on `out_valid` is identical to the gapless run, and outputs are stable during gaps.
- Assert reset after 7 samples of the 0x0800 run, then restart. The output sequence restarts from sample 0 exactly as in the original run.
- ORDER=2, DELAY=0, A = 0xF000 continuous: C=15/`Csgn`=0, then C=15/`Csgn`=1, then 0. With `ANS_STAGE_SAT_EN` and CMAX=7: C=7/0, then C=7/1, then 0, and `sat`=1 from the first sample onward.

Source files
------------

// File: rtl/ans_stage.sv
// ans_stage: one noise-shaping stage of the ANS-PWM cascade.
// Quantises each accepted sample to QB coarse bits with error feedback, applies an
// ORDER-fold first difference, delays the sign-magnitude result DELAY samples and
// forwards the left-aligned residue to the next stage.
// Optional feature: define ANS_STAGE_SAT_EN to clamp C to CMAX and drive the sticky sat flag.
module ans_stage #(
    parameter int unsigned W     = 16,
    parameter int unsigned QB    = 4,
    parameter int unsigned ORDER = 1,
    parameter int unsigned DELAY = 2,
    parameter int unsigned CMAX  = (32'd1 << (QB + ORDER + 1)) - 32'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [W-1:0]        A,
    output logic                out_valid,
    output logic [QB+ORDER:0]   C,
    output logic                Csgn,
    output logic [W-1:0]        nxttgt,
    output logic                sat
);

    localparam int unsigned OW = QB + ORDER + 1;
    localparam int unsigned RW = W - QB;
    // Arrays keep at least one entry so ORDER=0 / DELAY=0 still elaborate.
    localparam int unsigned HN = (ORDER > 0) ? ORDER : 1;
    localparam int unsigned DN = (DELAY > 0) ? DELAY : 1;

    logic [RW-1:0]        r_res;
    logic signed [OW:0]   r_hist [HN];
    logic [OW-1:0]        r_dmag [DN];
    logic                 r_dsgn [DN];
    logic                 r_out_valid;
    logic [OW-1:0]        r_c;
    logic                 r_csgn;
    logic [W-1:0]         r_nxt;

    logic [W:0]           w_sum;
    logic [QB:0]          w_q;
    logic [RW-1:0]        w_res_nxt;
    logic signed [OW:0]   w_y;
    logic signed [OW:0]   w_hist_nxt [HN];
    logic signed [OW:0]   w_d;
    logic                 w_sgn;
    logic [OW-1:0]        w_mag_raw;
    logic [OW-1:0]        w_mag;
    logic [OW-1:0]        w_dly_mag;
    logic                 w_dly_sgn;

    // Quantiser with error feedback: carry-out of A + residue is the coarse value.
    always_comb begin
        w_sum     = {1'b0, A} + {{(QB + 1){1'b0}}, r_res};
        w_q       = w_sum[W:RW];
        w_res_nxt = w_sum[RW-1:0];
    end

    // Cascade of first differences; each history word captures the stage input.
    always_comb begin
        w_y = signed'({{(ORDER + 1){1'b0}}, w_q});
        for (int k = 0; k < HN; k++) begin
            w_hist_nxt[k] = r_hist[k];
        end
        for (int k = 0; k < ORDER; k++) begin
            w_hist_nxt[k] = w_y;
            w_y           = w_y - r_hist[k];
        end
        w_d = w_y;
    end

    // Sign-magnitude conversion; |d| < 2^OW so the low OW bits of -d are exact.
    always_comb begin
        w_sgn     = w_d[OW];
        w_mag_raw = w_sgn ? (~w_d[OW-1:0] + 1'b1) : w_d[OW-1:0];
    end

`ifdef ANS_STAGE_SAT_EN
    localparam logic [OW-1:0] CMAX_W = CMAX[OW-1:0];
    logic w_clamp;
    logic r_sat;

    // Clamp the magnitude ahead of the delay line; sign is left untouched.
    always_comb begin
        w_clamp = (w_mag_raw > CMAX_W);
        w_mag   = w_clamp ? CMAX_W : w_mag_raw;
    end

    // Sticky saturation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (in_valid && w_clamp) begin
            r_sat <= 1'b1;
        end
    end

    assign sat = r_sat;
`else
    // No clamp in this build.
    always_comb begin
        w_mag = w_mag_raw;
    end

    assign sat = 1'b0;
`endif

    // Tap of the alignment delay line (bypassed entirely when DELAY is 0).
    always_comb begin
        if (DELAY == 0) begin
            w_dly_mag = w_mag;
            w_dly_sgn = w_sgn;
        end else begin
            w_dly_mag = r_dmag[DN-1];
            w_dly_sgn = r_dsgn[DN-1];
        end
    end

    // Pipeline state advances only on accepted samples; reset discards all history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_csgn      <= 1'b0;
            r_nxt       <= '0;
            for (int k = 0; k < HN; k++) begin
                r_hist[k] <= '0;
            end
            for (int k = 0; k < DN; k++) begin
                r_dmag[k] <= '0;
                r_dsgn[k] <= 1'b0;
            end
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_res <= w_res_nxt;
                for (int k = 0; k < HN; k++) begin
                    r_hist[k] <= w_hist_nxt[k];
                end
                r_dmag[0] <= w_mag;
                r_dsgn[0] <= w_sgn;
                for (int k = 1; k < DN; k++) begin
                    r_dmag[k] <= r_dmag[k-1];
                    r_dsgn[k] <= r_dsgn[k-1];
                end
                r_c    <= w_dly_mag;
                r_csgn <= w_dly_sgn;
                r_nxt  <= {w_res_nxt, {QB{1'b0}}};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign C         = r_c;
    assign Csgn      = r_csgn;
    assign nxttgt    = r_nxt;

endmodule

// File: tb/tb_ans_stage.sv
// Scoreboard bench for ans_stage: two instances (default parameters, and ORDER=2/DELAY=0/CMAX=7)
// share clock, reset and valid; a behavioural model pushes expected words on each accepted sample.
module tb_ans_stage;

`ifdef ANS_STAGE_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a0 = '0;
    logic [15:0] a1 = '0;

    logic        ov0, cs0, sat0;
    logic [5:0]  c0;
    logic [15:0] nt0;
    logic        ov1, cs1, sat1;
    logic [6:0]  c1;
    logic [15:0] nt1;

    always #5 clk = ~clk;

    ans_stage #(.W(16), .QB(4), .ORDER(1), .DELAY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a0),
        .out_valid(ov0), .C(c0), .Csgn(cs0), .nxttgt(nt0), .sat(sat0)
    );

    ans_stage #(.W(16), .QB(4), .ORDER(2), .DELAY(0), .CMAX(7)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a1),
        .out_valid(ov1), .C(c1), .Csgn(cs1), .nxttgt(nt1), .sat(sat1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state, one slot per instance.
    int m_order [2] = '{1, 2};
    int m_delay [2] = '{2, 0};
    int m_cmax  [2] = '{63, 7};
    int m_r     [2];
    int m_sat   [2];
    int m_h     [2][3];
    int m_dm    [2][9];
    int m_ds    [2][9];

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_r[i]   = 0;
            m_sat[i] = 0;
            for (int k = 0; k < 3; k++) m_h[i][k] = 0;
            for (int j = 0; j < 9; j++) begin
                m_dm[i][j] = 0;
                m_ds[i][j] = 0;
            end
        end
    endtask

    // Expected word layout: {6'b0, sat, Csgn, C[7:0], nxttgt[15:0]}.
    task automatic model_step(input int i, input int a, output logic [31:0] e);
        int s, q, y, t, mag, sg, oc, os, nt;
        s      = a + m_r[i];
        q      = s >> 12;
        m_r[i] = s & 'hFFF;
        nt     = (m_r[i] << 4) & 'hFFFF;
        y      = q;
        for (int k = 0; k < m_order[i]; k++) begin
            t         = y - m_h[i][k];
            m_h[i][k] = y;
            y         = t;
        end
        sg  = (y < 0) ? 1 : 0;
        mag = (y < 0) ? -y : y;
        if (SatEn && mag > m_cmax[i]) begin
            mag      = m_cmax[i];
            m_sat[i] = 1;
        end
        if (m_delay[i] == 0) begin
            oc = mag;
            os = sg;
        end else begin
            oc = m_dm[i][m_delay[i]-1];
            os = m_ds[i][m_delay[i]-1];
            for (int j = m_delay[i] - 1; j > 0; j--) begin
                m_dm[i][j] = m_dm[i][j-1];
                m_ds[i][j] = m_ds[i][j-1];
            end
            m_dm[i][0] = mag;
            m_ds[i][0] = sg;
        end
        e = {6'b0, m_sat[i][0], os[0], oc[7:0], nt[15:0]};
    endtask

    task automatic drive(input logic v, input logic [15:0] x0, input logic [15:0] x1);
        logic [31:0] e;
        @(posedge clk);
        #1;
        in_valid = v;
        a0       = x0;
        a1       = x1;
        if (v) begin
            model_step(0, int'(x0), e);
            q0.push_back(e);
            model_step(1, int'(x1), e);
            q1.push_back(e);
        end
    endtask

    // Three reset clocks with in_valid high and full-scale input, which must be ignored.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a0       = 16'hFFFF;
        a1       = 16'hFFFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    // Monitor: what the edge should have done, captured at the edge itself.
    logic pend     = 1'b0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        pend     <= rst_n && in_valid;
        rst_seen <= !rst_n;
    end

    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    always @(negedge clk) begin
        logic [31:0] cur0, cur1;
        cur0 = last0;
        cur1 = last1;
        if (rst_seen) begin
            cur0 = '0;
            cur1 = '0;
        end
        check_eq("out_valid0", {31'b0, ov0}, {31'b0, pend});
        check_eq("out_valid1", {31'b0, ov1}, {31'b0, pend});
        if (pend) begin
            if (q0.size() == 0) check_eq("sb_nonempty0", 32'(q0.size()), 32'd1);
            else cur0 = q0.pop_front();
            if (q1.size() == 0) check_eq("sb_nonempty1", 32'(q1.size()), 32'd1);
            else cur1 = q1.pop_front();
        end
        check_eq(pend ? "sample0" : "hold0", {6'b0, sat0, cs0, 2'b0, c0, nt0}, cur0);
        check_eq(pend ? "sample1" : "hold1", {6'b0, sat1, cs1, 1'b0, c1, nt1}, cur1);
        last0 <= cur0;
        last1 <= cur1;
    end

    initial begin
        model_reset();
        do_reset();

        // Constant half scale; second instance sees 0xF000.
        for (int i = 0; i < 8; i++) drive(1'b1, 16'h8000, 16'hF000);

        // Alternating coarse value, gapless.
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, 16'h0800, 16'hF000);

        // Same run with five idle gaps carrying junk on A.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 16'h0800, 16'hF000);
            if (i % 2 == 1 && i < 10) begin
                repeat ($urandom_range(1, 4)) drive(1'b0, 16'($urandom), 16'($urandom));
            end
        end

        // Reset mid-stream after 7 samples, then restart from scratch.
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 16'h0800, 16'hF000);
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, 16'h0800, 16'hF000);

        // Random inputs with random valid.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
        end

        repeat (3) drive(1'b0, 16'h0000, 16'h0000);
        check_eq("drain0", 32'(q0.size()), 32'd0);
        check_eq("drain1", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
